// File: rtl/lock_controller.sv
// Keypad lock: set a CODE_LEN-digit code while unlocked, re-enter it to unlock, lock out after repeated misses.
// Latency: every output is a flop; unlocked/lockedOut/error/counters update on the edge that samples the key.
// Backpressure: none; keys arriving during lockout, or with zero/multiple bits set, are dropped.
module lock_controller #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int ENTRY_TIMEOUT  = 250000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keyEdge,
    output logic       unlocked,
    output logic       lockedOut,
    output logic       error,
    output logic [3:0] digitCount,
    output logic [3:0] attempts
);

    localparam int CW = 2 * CODE_LEN;          // full code width
    localparam int EW = 2 * (CODE_LEN - 1);    // digits held before the final one arrives
    localparam int LW = $clog2(LOCKOUT_CYCLES);
    localparam int TW = $clog2(ENTRY_TIMEOUT);

    localparam logic [3:0]    LAST_CNT     = 4'(CODE_LEN - 1);
    localparam logic [3:0]    MAX_A        = 4'(MAX_ATTEMPTS);
    localparam logic [3:0]    ATT_LAST     = 4'(MAX_ATTEMPTS - 1);
    localparam logic [LW-1:0] LOCK_LOAD    = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ENTRY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_LOCKED   = 2'd1,
        S_LOCKOUT  = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] code_q, code_nxt;
    logic [EW-1:0] entry_q, entry_nxt;
    logic [3:0]    count_q, count_nxt;
    logic [3:0]    att_q, att_nxt;
    logic [TW-1:0] timer_q, timer_nxt;
    logic [LW-1:0] lock_q, lock_nxt;
    logic          err_nxt;

    logic          key_vld;
    logic [1:0]    key_dat;
    logic [CW-1:0] entry_full;
    logic          timeout;

    // Exactly one bit set is a key press; anything else is treated as no key.
    assign key_vld = (keyEdge == 4'b0001) || (keyEdge == 4'b0010) ||
                     (keyEdge == 4'b0100) || (keyEdge == 4'b1000);
    assign key_dat = {keyEdge[3] | keyEdge[2], keyEdge[3] | keyEdge[1]};

    // The entry including the digit on the bus, first digit most significant.
    assign entry_full = {entry_q, key_dat};
    assign timeout    = (count_q != 4'd0) && (timer_q == TIMEOUT_LAST);

    assign digitCount = count_q;
    assign attempts   = att_q;

    // Next-state, entry, attempt, timer and lockout-counter logic.
    always_comb begin
        state_nxt = state_q;
        code_nxt  = code_q;
        entry_nxt = entry_q;
        count_nxt = count_q;
        att_nxt   = att_q;
        timer_nxt = '0;
        lock_nxt  = lock_q;
        err_nxt   = 1'b0;
        case (state_q)
            S_UNLOCKED, S_LOCKED: begin
                if (key_vld) begin
                    // A key always beats a timeout landing on the same cycle.
                    if (count_q == LAST_CNT) begin
                        count_nxt = 4'd0;
                        entry_nxt = '0;
                        if (state_q == S_UNLOCKED) begin
                            code_nxt  = entry_full;
                            state_nxt = S_LOCKED;
                        end else if (entry_full == code_q) begin
                            state_nxt = S_UNLOCKED;
                            att_nxt   = 4'd0;
                        end else begin
                            err_nxt = 1'b1;
                            if (att_q == ATT_LAST) begin
                                att_nxt   = MAX_A;
                                state_nxt = S_LOCKOUT;
                                lock_nxt  = LOCK_LOAD;
                            end else begin
                                att_nxt = att_q + 4'd1;
                            end
                        end
                    end else begin
                        entry_nxt = entry_full[EW-1:0];
                        count_nxt = count_q + 4'd1;
                    end
                end else if (timeout) begin
                    // Abandoned partial entry: drop it silently.
                    count_nxt = 4'd0;
                    entry_nxt = '0;
                end else if (count_q != 4'd0) begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (lock_q == '0) begin
                    state_nxt = S_LOCKED;
                    att_nxt   = 4'd0;
                end else begin
                    lock_nxt = lock_q - LW'(1);
                end
            end
            default: begin
                state_nxt = S_UNLOCKED;
            end
        endcase
    end

    // State and output registers; outputs are decoded from next state so they move with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_UNLOCKED;
            code_q    <= '0;
            entry_q   <= '0;
            count_q   <= 4'd0;
            att_q     <= 4'd0;
            timer_q   <= '0;
            lock_q    <= '0;
            unlocked  <= 1'b1;
            lockedOut <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            code_q    <= code_nxt;
            entry_q   <= entry_nxt;
            count_q   <= count_nxt;
            att_q     <= att_nxt;
            timer_q   <= timer_nxt;
            lock_q    <= lock_nxt;
            unlocked  <= (state_nxt == S_UNLOCKED);
            lockedOut <= (state_nxt == S_LOCKOUT);
            error     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios with literal expectations plus randomized keys.
// A digit-queue model of the lock is compared against every output on each falling clock edge.
// Inputs are driven on the falling edge; the model advances on the rising edge with the DUT.
module tb_lock_controller;

    localparam int CODE_LEN = 4;
    localparam int MAX_ATT  = 3;
    localparam int LOCK_CYC = 16;
    localparam int TMO      = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] keyEdge;
    logic       unlocked;
    logic       lockedOut;
    logic       error;
    logic [3:0] digitCount;
    logic [3:0] attempts;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lock_controller #(
        .CODE_LEN      (CODE_LEN),
        .MAX_ATTEMPTS  (MAX_ATT),
        .LOCKOUT_CYCLES(LOCK_CYC),
        .ENTRY_TIMEOUT (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .keyEdge   (keyEdge),
        .unlocked  (unlocked),
        .lockedOut (lockedOut),
        .error     (error),
        .digitCount(digitCount),
        .attempts  (attempts)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int  m_code[CODE_LEN];
    int  m_entry[$];
    bit  m_unl  = 1'b1;
    int  m_left = 0;     // lockout cycles still to serve
    int  m_att  = 0;
    bit  m_err  = 1'b0;
    int  m_idle = 0;

    task automatic model_reset();
        foreach (m_code[i]) m_code[i] = 0;
        m_entry.delete();
        m_unl  = 1'b1;
        m_left = 0;
        m_att  = 0;
        m_err  = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_step(input logic [3:0] k);
        int  d;
        bit  same;
        m_err = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_att = 0;
        end else if ($countones(k) == 1) begin
            d = 0;
            for (int j = 0; j < 4; j++) if (k[j]) d = j;
            m_entry.push_back(d);
            m_idle = 0;
            if (m_entry.size() == CODE_LEN) begin
                if (m_unl) begin
                    for (int j = 0; j < CODE_LEN; j++) m_code[j] = m_entry[j];
                    m_unl = 1'b0;
                end else begin
                    same = 1'b1;
                    for (int j = 0; j < CODE_LEN; j++) if (m_code[j] != m_entry[j]) same = 1'b0;
                    if (same) begin
                        m_unl = 1'b1;
                        m_att = 0;
                    end else begin
                        m_err = 1'b1;
                        m_att++;
                        if (m_att == MAX_ATT) m_left = LOCK_CYC;
                    end
                end
                m_entry.delete();
            end
        end else if (m_entry.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_entry.delete();
                m_idle = 0;
            end
        end
    endtask

    // Model advances with the DUT and resets asynchronously alongside it.
    always begin
        @(posedge clock or negedge reset);
        if (!reset) model_reset();
        else        model_step(keyEdge);
    end

    // Per-cycle comparison of every output against the model.
    always begin
        @(negedge clock);
        chk("unlocked",   int'(unlocked),   int'(m_unl && m_left == 0));
        chk("lockedOut",  int'(lockedOut),  int'(m_left > 0));
        chk("error",      int'(error),      int'(m_err));
        chk("digitCount", int'(digitCount), m_entry.size());
        chk("attempts",   int'(attempts),   m_att);
        chk("exclusive",  int'(unlocked & lockedOut), 0);
    end

    // ---------------- stimulus ----------------
    task automatic press(input int d);
        @(negedge clock);
        keyEdge = 4'(1 << d);
        @(negedge clock);
        keyEdge = 4'b0000;
    endtask

    task automatic junk(input logic [3:0] v);
        @(negedge clock);
        keyEdge = v;
        @(negedge clock);
        keyEdge = 4'b0000;
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    initial begin
        int n;
        int r;
        keyEdge = 4'b0000;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_unlocked",   int'(unlocked),   1);
        chk("rst_lockedOut",  int'(lockedOut),  0);
        chk("rst_error",      int'(error),      0);
        chk("rst_digitCount", int'(digitCount), 0);
        chk("rst_attempts",   int'(attempts),   0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Set code 1230.
        press(1); press(2); press(3);
        chk("set_partial_count", int'(digitCount), 3);
        chk("set_partial_unl",   int'(unlocked),   1);
        press(0);
        chk("set_unl_fall",  int'(unlocked),   0);
        chk("set_count_clr", int'(digitCount), 0);

        // Correct code unlocks one cycle after the final pulse.
        enter(1, 2, 3, 0);
        chk("open_unl", int'(unlocked), 1);
        chk("open_att", int'(attempts), 0);

        // Re-lock, then three wrong codes into lockout.
        enter(1, 2, 3, 0);
        chk("relock_unl", int'(unlocked), 0);
        for (int a = 1; a <= MAX_ATT; a++) begin
            enter(0, 0, 0, 0);
            chk("wrong_error", int'(error),    1);
            chk("wrong_att",   int'(attempts), a);
        end
        chk("lockout_set", int'(lockedOut), 1);

        // Keys during lockout are dropped.
        enter(1, 2, 3, 0);
        chk("lockout_hold",  int'(lockedOut),  1);
        chk("lockout_count", int'(digitCount), 0);
        chk("lockout_unl",   int'(unlocked),   0);
        n = 8;
        while (lockedOut && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("lockout_len",   n, LOCK_CYC);
        chk("lockout_att",   int'(attempts),  0);
        enter(1, 2, 3, 0);
        chk("post_lockout_unl", int'(unlocked), 1);

        // Invalid patterns ignored; partial entry times out without penalty.
        enter(1, 2, 3, 0);
        enter(0, 0, 0, 0);
        chk("one_wrong_att", int'(attempts), 1);
        press(1);
        junk(4'b0110);
        junk(4'b0000);
        press(2);
        chk("junk_count", int'(digitCount), 2);
        repeat (7) @(negedge clock);
        chk("pre_timeout_count", int'(digitCount), 2);
        @(negedge clock);
        chk("timeout_count", int'(digitCount), 0);
        chk("timeout_error", int'(error),      0);
        chk("timeout_att",   int'(attempts),   1);
        enter(1, 2, 3, 0);
        chk("after_timeout_unl", int'(unlocked), 1);
        chk("after_timeout_att", int'(attempts), 0);

        // Asynchronous reset in the middle of a lockout.
        enter(1, 2, 3, 0);
        repeat (MAX_ATT) enter(0, 0, 0, 0);
        chk("lockout2_set", int'(lockedOut), 1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_unlocked",   int'(unlocked),   1);
        chk("arst_lockedOut",  int'(lockedOut),  0);
        chk("arst_error",      int'(error),      0);
        chk("arst_digitCount", int'(digitCount), 0);
        chk("arst_attempts",   int'(attempts),   0);
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic; digits biased to 0/1 so matches occur regularly.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            r = $urandom_range(0, 99);
            if (r < 40)      keyEdge = 4'(1 << $urandom_range(0, 1));
            else if (r < 45) keyEdge = 4'(1 << $urandom_range(2, 3));
            else if (r < 55) keyEdge = 4'($urandom_range(0, 15));
            else             keyEdge = 4'b0000;
            if (r == 99) begin
                keyEdge = 4'b0000;
                repeat (9) @(negedge clock);
            end
            if (i % 750 == 700) begin
                #2 reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end
        end
        keyEdge = 4'b0000;
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter CODE_LEN, 4, number of digits in a passcode (2..8).
REQ-002 Parameter MAX_ATTEMPTS, 3, consecutive wrong codes that trigger lockout (1..15).
REQ-003 Parameter LOCKOUT_CYCLES, 50000000, clock cycles spent in lockout (>=2).
REQ-004 Parameter ENTRY_TIMEOUT, 250000000, idle clock cycles after which a partial entry is discarded (>=2).
REQ-005 clock  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clock.
REQ-007 keyEdge  input  4  one-cycle rising-edge pulses from per-button edge detectors; bit i = digit value i.
REQ-008 unlocked  output  1  registered, high while in UNLOCKED.
REQ-009 lockedOut  output  1  registered, high while in LOCKOUT.
REQ-010 error  output  1  registered, one-cycle pulse on a rejected code.
REQ-011 digitCount  output  4  registered, digits accepted in the current entry (0..CODE_LEN-1).
REQ-012 attempts  output  4  registered, consecutive wrong codes since last success or lockout expiry.

Function
REQ-013 States: UNLOCKED (set new code), LOCKED (enter code), LOCKOUT; one-hot or binary encoding is implementer's choice.
REQ-014 Valid key cycle: exactly one keyEdge bit high; zero or multiple bits high SHALL be ignored with no state, count or timer change.
REQ-015 Each valid key appends its 2-bit digit value to an entry shift register (2*CODE_LEN bits, first digit most significant) and increments digitCount.
REQ-016 UNLOCKED: on the valid key completing CODE_LEN digits, stored code <= entry, digitCount <= 0, state <= LOCKED, unlocked falls on the same edge.
REQ-017 LOCKED: on the valid key completing CODE_LEN digits, compare full entry (including that digit) against stored code; digitCount <= 0.
REQ-018 Match: state <= UNLOCKED, attempts <= 0; unlocked high from the edge that sampled the final digit (latency 1 cycle after key pulse).
REQ-019 Mismatch with attempts+1 < MAX_ATTEMPTS: attempts increments, error pulses for one cycle, state stays LOCKED.
REQ-020 Mismatch with attempts+1 == MAX_ATTEMPTS: error pulses, attempts <= MAX_ATTEMPTS, state <= LOCKOUT, lockout counter loaded with LOCKOUT_CYCLES-1.
REQ-021 LOCKOUT: all keys ignored; counter decrements each cycle; on the cycle the counter is 0, state <= LOCKED, attempts <= 0, lockedOut falls.
REQ-022 Entry timer: cleared on every valid key and whenever digitCount is 0; counts while digitCount > 0 in UNLOCKED or LOCKED.
REQ-023 Timer reaching ENTRY_TIMEOUT-1 with no valid key that cycle: digitCount <= 0, entry discarded, no error, attempts unchanged, state unchanged.
REQ-024 Timeout and valid key in the same cycle: key wins, timer cleared, digit accepted.
REQ-025 Counter widths SHALL be $clog2 of their parameter; no wrap-around permitted in any counter.
REQ-026 error never asserted in UNLOCKED or LOCKOUT; unlocked and lockedOut never both high.

Reset
REQ-027 reset low: state UNLOCKED, unlocked=1, lockedOut=0, error=0, digitCount=0, attempts=0, stored code=all zeros, entry, timer and lockout counter cleared.
REQ-028 reset asserted mid-entry, mid-lockout or during error pulse SHALL abort the operation and give REQ-027 values asynchronously; first valid key accepted on the first rising edge after reset deasserts.

Verification (CODE_LEN=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16, ENTRY_TIMEOUT=8)
REQ-029 After reset, keys 1,2,3,0 -> unlocked falls after key 0; then 1,2,3,0 -> unlocked=1 one cycle after final pulse, attempts=0.
REQ-030 Code 1230 set, enter 0,0,0,0 three times -> error pulses 3 times, attempts 1,2,3, lockedOut=1 after third; exactly 16 cycles later lockedOut=0, attempts=0.
REQ-031 During lockout press 1,2,3,0 -> no change; after expiry 1,2,3,0 -> unlocked=1.
REQ-032 In LOCKED press 1,2 then idle 8 cycles -> digitCount returns 0, error=0, attempts unchanged; then 1,2,3,0 -> unlocked=1.
REQ-033 keyEdge=4'b0110 or 4'b0000 pulses interleaved with entry -> ignored, digitCount unchanged.
REQ-034 reset pulsed low mid-lockout with no clock edge -> outputs immediately match REQ-027, stored code back to 0000.
